// File: rtl/lsu_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_arbiter
//
// Shares one LSU port between two requesters. Requester 0 is the CPU memory
// stage and requester 1 is the debug/DMA port. Every accepted request goes
// through a fixed multi-cycle sequence. The latched address and control stay
// stable on the LSU port for the whole access. Load data is captured at the
// end of the access and returned with a one-cycle response pulse. Misaligned
// or malformed requests never reach the LSU as a write, and they are answered
// with an error response.
//
// Parameters
//   FIXED_PRIO          0: round-robin on conflict, 1: requester 0 always wins
//
// Ports
//   i_clk, i_reset      clock and synchronous active-high reset
//   i_reqN_valid        request N pending, held stable until accepted
//   o_reqN_ready        request N accepted this cycle (valid & ready)
//   i_reqN_addr         byte address
//   i_reqN_wdata        store data, right-aligned
//   i_reqN_wren         1 = store, 0 = load
//   i_reqN_load_type    0001 byte, 0011 halfword, 1111 word
//   i_reqN_load_signed  sign-extend loads
//   o_rspN_valid        one-cycle response pulse for requester N
//   o_rspN_rdata        load result, 0 for stores and errors
//   o_rspN_err          request was rejected (qualified by o_rspN_valid)
//   o_lsu_*             latched request presented to the LSU
//   i_lsu_ld_data       load data returned by the LSU
// ---------------------------------------------------------------------------
module lsu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_addr,
  input  logic [31:0] i_req0_wdata,
  input  logic        i_req0_wren,
  input  logic [3:0]  i_req0_load_type,
  input  logic        i_req0_load_signed,
  output logic        o_rsp0_valid,
  output logic [31:0] o_rsp0_rdata,
  output logic        o_rsp0_err,

  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_addr,
  input  logic [31:0] i_req1_wdata,
  input  logic        i_req1_wren,
  input  logic [3:0]  i_req1_load_type,
  input  logic        i_req1_load_signed,
  output logic        o_rsp1_valid,
  output logic [31:0] o_rsp1_rdata,
  output logic        o_rsp1_err,

  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic        o_lsu_wren,
  output logic [3:0]  o_lsu_load_type,
  output logic        o_lsu_load_signed,
  input  logic [31:0] i_lsu_ld_data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ST_ACC = 3'd1;
  localparam logic [2:0] LD_ACC = 3'd2;
  localparam logic [2:0] LD_CAP = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wren_q, wren_d;
  logic [3:0]  load_type_q, load_type_d;
  logic        load_signed_q, load_signed_d;

  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic        rsp0_err_q, rsp0_err_d;
  logic        rsp1_err_q, rsp1_err_d;
  logic [31:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [31:0] rsp1_rdata_q, rsp1_rdata_d;

  logic        grant0, grant1;
  logic        accept;
  logic        rsp_fire;

  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_wren;
  logic [3:0]  sel_load_type;
  logic        sel_load_signed;
  logic        sel_bad;

  // Conflict resolution. With round-robin, last_grant_q names the requester
  // that won most recently, so the other one wins the next conflict. Reset
  // leaves last_grant_q at 1 so requester 0 wins the first conflict.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      if (FIXED_PRIO || last_grant_q) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = i_req0_valid;
      grant1 = i_req1_valid;
    end
  end

  assign o_req0_ready = (state_q == IDLE) & grant0 & ~i_reset;
  assign o_req1_ready = (state_q == IDLE) & grant1 & ~i_reset;
  assign accept       = o_req0_ready | o_req1_ready;

  // Fields of whichever requester is granted. The mux is only used on accept.
  always_comb begin
    if (grant1) begin
      sel_addr        = i_req1_addr;
      sel_wdata       = i_req1_wdata;
      sel_wren        = i_req1_wren;
      sel_load_type   = i_req1_load_type;
      sel_load_signed = i_req1_load_signed;
    end else begin
      sel_addr        = i_req0_addr;
      sel_wdata       = i_req0_wdata;
      sel_wren        = i_req0_wren;
      sel_load_type   = i_req0_load_type;
      sel_load_signed = i_req0_load_signed;
    end
  end

  // A request is malformed when the size code is unknown or when the address
  // is not naturally aligned for that size. Such requests are diverted to ERR
  // so that memory and I/O registers are never touched.
  always_comb begin
    sel_bad = 1'b0;
    case (sel_load_type)
      4'b0001: sel_bad = 1'b0;
      4'b0011: sel_bad = sel_addr[0];
      4'b1111: sel_bad = |sel_addr[1:0];
      default: sel_bad = 1'b1;
    endcase
  end

  // Sequencer. The request is latched on accept, and the fixed access
  // sequence that follows depends only on the latched request.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wren_d        = wren_q;
    load_type_d   = load_type_q;
    load_signed_d = load_signed_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d          = grant1;
          last_grant_d  = grant1;
          addr_d        = sel_addr;
          wdata_d       = sel_wdata;
          wren_d        = sel_wren;
          load_type_d   = sel_load_type;
          load_signed_d = sel_load_signed;
          if (sel_bad) begin
            state_d = ERR;
          end else if (sel_wren) begin
            state_d = ST_ACC;
          end else begin
            state_d = LD_ACC;
          end
        end
      end
      ST_ACC:  state_d = IDLE;
      LD_ACC:  state_d = LD_CAP;
      LD_CAP:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The response is registered on the way out of each terminal state, so the
  // pulse lands in the IDLE cycle that follows. Only the latched requester
  // sees it. rdata is zero unless the access was a completed load.
  always_comb begin
    rsp_fire     = (state_q == ST_ACC) | (state_q == LD_CAP) | (state_q == ERR);
    rsp0_valid_d = rsp_fire & ~id_q;
    rsp1_valid_d = rsp_fire & id_q;
    rsp0_err_d   = (state_q == ERR) & ~id_q;
    rsp1_err_d   = (state_q == ERR) & id_q;
    rsp0_rdata_d = ((state_q == LD_CAP) && !id_q) ? i_lsu_ld_data : 32'd0;
    rsp1_rdata_d = ((state_q == LD_CAP) && id_q) ? i_lsu_ld_data : 32'd0;
  end

  // State and latched request. A reset in the middle of an access drops
  // the access. No response is produced for it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      wren_q        <= 1'b0;
      load_type_q   <= 4'd0;
      load_signed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wren_q        <= wren_d;
      load_type_q   <= load_type_d;
      load_signed_q <= load_signed_d;
    end
  end

  // Response registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp0_rdata_q <= 32'd0;
      rsp1_rdata_q <= 32'd0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign o_rsp0_valid = rsp0_valid_q;
  assign o_rsp1_valid = rsp1_valid_q;
  assign o_rsp0_err   = rsp0_err_q;
  assign o_rsp1_err   = rsp1_err_q;
  assign o_rsp0_rdata = rsp0_rdata_q;
  assign o_rsp1_rdata = rsp1_rdata_q;

  // The write strobe is gated by reset combinationally. A reset that arrives
  // during ST_ACC therefore cannot let the store reach memory.
  assign o_lsu_addr        = addr_q;
  assign o_lsu_st_data     = wdata_q;
  assign o_lsu_wren        = (state_q == ST_ACC) & ~i_reset;
  assign o_lsu_load_type   = load_type_q;
  assign o_lsu_load_signed = load_signed_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_arbiter
//
// Testbench for lsu_arbiter.
// The main instance uses round-robin arbitration. A behavioural model tracks
// it as a timeline of scheduled events: when each requester is next free, and
// when each write, capture and response is due. A negedge process compares the
// instance against this model on every cycle.
// A second instance uses FIXED_PRIO=1. It has both requests held valid, which
// shows that requester 0 always wins.
// ---------------------------------------------------------------------------
module tb_lsu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  reqValid;
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic        reqWren   [2];
  logic [3:0]  reqType   [2];
  logic        reqSigned [2];
  logic [31:0] ldData;

  logic        rdy0, rdy1;
  logic        rspValid0, rspValid1, rspErr0, rspErr1;
  logic [31:0] rspRdata0, rspRdata1;
  logic [31:0] lsuAddr, lsuStData;
  logic        lsuWren, lsuSigned;
  logic [3:0]  lsuType;

  // Nets of the fixed-priority instance.
  logic        fpRdy0, fpRdy1;
  logic        fpRspValid0, fpRspValid1, fpRspErr0, fpRspErr1;
  logic [31:0] fpRspRdata0, fpRspRdata1, fpLsuAddr, fpLsuStData;
  logic        fpLsuWren, fpLsuSigned;
  logic [3:0]  fpLsuType;

  lsu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(reqValid[0]), .o_req0_ready(rdy0),
    .i_req0_addr(reqAddr[0]), .i_req0_wdata(reqWdata[0]),
    .i_req0_wren(reqWren[0]), .i_req0_load_type(reqType[0]),
    .i_req0_load_signed(reqSigned[0]),
    .o_rsp0_valid(rspValid0), .o_rsp0_rdata(rspRdata0), .o_rsp0_err(rspErr0),
    .i_req1_valid(reqValid[1]), .o_req1_ready(rdy1),
    .i_req1_addr(reqAddr[1]), .i_req1_wdata(reqWdata[1]),
    .i_req1_wren(reqWren[1]), .i_req1_load_type(reqType[1]),
    .i_req1_load_signed(reqSigned[1]),
    .o_rsp1_valid(rspValid1), .o_rsp1_rdata(rspRdata1), .o_rsp1_err(rspErr1),
    .o_lsu_addr(lsuAddr), .o_lsu_st_data(lsuStData), .o_lsu_wren(lsuWren),
    .o_lsu_load_type(lsuType), .o_lsu_load_signed(lsuSigned),
    .i_lsu_ld_data(ldData)
  );

  lsu_arbiter #(.FIXED_PRIO(1'b1)) dutFixed (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(1'b1), .o_req0_ready(fpRdy0),
    .i_req0_addr(32'h0000_0100), .i_req0_wdata(32'd0),
    .i_req0_wren(1'b0), .i_req0_load_type(4'b1111),
    .i_req0_load_signed(1'b0),
    .o_rsp0_valid(fpRspValid0), .o_rsp0_rdata(fpRspRdata0), .o_rsp0_err(fpRspErr0),
    .i_req1_valid(1'b1), .o_req1_ready(fpRdy1),
    .i_req1_addr(32'h0000_0200), .i_req1_wdata(32'd0),
    .i_req1_wren(1'b0), .i_req1_load_type(4'b1111),
    .i_req1_load_signed(1'b0),
    .o_rsp1_valid(fpRspValid1), .o_rsp1_rdata(fpRspRdata1), .o_rsp1_err(fpRspErr1),
    .o_lsu_addr(fpLsuAddr), .o_lsu_st_data(fpLsuStData), .o_lsu_wren(fpLsuWren),
    .o_lsu_load_type(fpLsuType), .o_lsu_load_signed(fpLsuSigned),
    .i_lsu_ld_data(32'd0)
  );

  int checks = 0;
  int errors = 0;

  // Compares one value and records the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Cycle index. It advances on every rising edge.
  int cycNow = 0;
  always @(posedge clk) cycNow <= cycNow + 1;

  // Behavioural model state. Events are kept as absolute cycle numbers.
  bit          synced = 1'b0;
  int          freeAt = 0;
  int          wrCycle = -1;
  int          capCycle = -1;
  int          respCycle = -1;
  int          respId = 0;
  bit          respErr = 1'b0;
  bit          respLoad = 1'b0;
  logic [31:0] capData = 32'd0;
  logic [31:0] mAddr = 32'd0, mWdata = 32'd0;
  logic        mWren = 1'b0, mSigned = 1'b0;
  logic [3:0]  mType = 4'd0;
  int          lastGrant = 1;
  bit   [1:0]  accFlag = 2'b00;
  int          accCyc = -1;

  function automatic bit isMalformed(input logic [3:0] t, input logic [31:0] a);
    if (t == 4'b0001) return 1'b0;
    if (t == 4'b0011) return (a % 2) != 0;
    if (t == 4'b1111) return (a % 4) != 0;
    return 1'b1;
  endfunction

  // Model update and compare. This runs once per cycle, in the middle of the
  // cycle, while the inputs are stable.
  always @(negedge clk) begin
    int  c;
    int  winner;
    bit  expRsp0, expRsp1;
    logic [31:0] expRdata;
    c = cycNow;
    winner = -1;
    if (c >= freeAt && !rst) begin
      if (reqValid == 2'b11) winner = 1 - lastGrant;
      else if (reqValid[0]) winner = 0;
      else if (reqValid[1]) winner = 1;
    end
    if (synced) begin
      expRsp0  = (c == respCycle) && (respId == 0);
      expRsp1  = (c == respCycle) && (respId == 1);
      expRdata = respLoad ? capData : 32'd0;
      checkOutput("ready0", rdy0, winner == 0);
      checkOutput("ready1", rdy1, winner == 1);
      checkOutput("lsu_wren", lsuWren, (c == wrCycle) && !rst);
      checkOutput("lsu_addr", lsuAddr, mAddr);
      checkOutput("lsu_st_data", lsuStData, mWdata);
      checkOutput("lsu_load_type", lsuType, mType);
      checkOutput("lsu_load_signed", lsuSigned, mSigned);
      checkOutput("rsp0_valid", rspValid0, expRsp0);
      checkOutput("rsp1_valid", rspValid1, expRsp1);
      if (expRsp0) begin
        checkOutput("rsp0_err", rspErr0, respErr);
        checkOutput("rsp0_rdata", rspRdata0, expRdata);
      end
      if (expRsp1) begin
        checkOutput("rsp1_err", rspErr1, respErr);
        checkOutput("rsp1_rdata", rspRdata1, expRdata);
      end
    end
    accFlag = 2'b00;
    if (c == capCycle) capData = ldData;
    if (rst) begin
      synced = 1'b1;
      freeAt = c + 1;
      wrCycle = -1;
      capCycle = -1;
      respCycle = -1;
      mAddr = 32'd0;
      mWdata = 32'd0;
      mWren = 1'b0;
      mType = 4'd0;
      mSigned = 1'b0;
      lastGrant = 1;
    end else if (winner >= 0) begin
      accFlag[winner] = 1'b1;
      accCyc = c;
      lastGrant = winner;
      mAddr = reqAddr[winner];
      mWdata = reqWdata[winner];
      mWren = reqWren[winner];
      mType = reqType[winner];
      mSigned = reqSigned[winner];
      respId = winner;
      respErr = isMalformed(mType, mAddr);
      respLoad = !respErr && !mWren;
      if (respErr) begin
        freeAt = c + 2;
        respCycle = c + 2;
      end else if (mWren) begin
        wrCycle = c + 1;
        freeAt = c + 2;
        respCycle = c + 2;
      end else begin
        capCycle = c + 2;
        freeAt = c + 3;
        respCycle = c + 3;
      end
    end
  end

  // Moves forward one cycle to the point where combinational outputs are
  // stable.
  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // Presents one request and waits, within a bounded number of cycles, until
  // the model reports it accepted. Returns 2 ns into the cycle after the
  // accept, with valid already dropped.
  task automatic applyStimulus(input int id, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic wren,
                               input logic [3:0] ltype, input logic lsigned);
    bit done;
    reqAddr[id] = addr;
    reqWdata[id] = wdata;
    reqWren[id] = wren;
    reqType[id] = ltype;
    reqSigned[id] = lsigned;
    reqValid[id] = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk);
      #1;
      if (accFlag[id] && accCyc == cycNow - 1) done = 1'b1;
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    reqValid[id] = 1'b0;
    #1;
  endtask

  initial begin
    int recId [4];
    int recCyc [4];
    int nRec;
    int fpCount;
    int baseCyc;

    rst = 1'b1;
    reqValid = 2'b00;
    ldData = 32'd0;
    for (int i = 0; i < 2; i++) begin
      reqAddr[i] = 32'd0;
      reqWdata[i] = 32'd0;
      reqWren[i] = 1'b0;
      reqType[i] = 4'b1111;
      reqSigned[i] = 1'b0;
    end

    // While reset is held, ready must stay low even with a valid request.
    stepCycle();
    stepCycle();
    reqValid[0] = 1'b1;
    #1;
    checkOutput("ready_in_reset", rdy0, 1'b0);
    checkOutput("fp_ready_in_reset", fpRdy0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reqValid[0] = 1'b0;
    #1;
    checkOutput("reset_lsu_addr", lsuAddr, 32'd0);
    checkOutput("reset_lsu_wren", lsuWren, 1'b0);
    checkOutput("reset_rsp0_valid", rspValid0, 1'b0);

    // Single store from requester 0.
    applyStimulus(0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b0);
    checkOutput("store_wren_t1", lsuWren, 1'b1);
    checkOutput("store_addr_t1", lsuAddr, 32'h0000_0010);
    checkOutput("store_data_t1", lsuStData, 32'hDEAD_BEEF);
    stepCycle();
    checkOutput("store_wren_t2", lsuWren, 1'b0);
    checkOutput("store_rsp0_t2", rspValid0, 1'b1);
    checkOutput("store_err_t2", rspErr0, 1'b0);

    // Single signed-byte load from requester 1.
    ldData = 32'hFFFF_FF80;
    applyStimulus(1, 32'h0000_0013, 32'd0, 1'b0, 4'b0001, 1'b1);
    checkOutput("load_wren_t1", lsuWren, 1'b0);
    stepCycle();
    checkOutput("load_rsp1_t2", rspValid1, 1'b0);
    stepCycle();
    checkOutput("load_rsp1_t3", rspValid1, 1'b1);
    checkOutput("load_rdata_t3", rspRdata1, 32'hFFFF_FF80);
    checkOutput("load_rsp0_t3", rspValid0, 1'b0);

    // Misaligned word store, then an unknown size code.
    applyStimulus(0, 32'h0000_0002, 32'h1111_2222, 1'b1, 4'b1111, 1'b0);
    checkOutput("misal_wren_t1", lsuWren, 1'b0);
    stepCycle();
    checkOutput("misal_rsp0_t2", rspValid0, 1'b1);
    checkOutput("misal_err_t2", rspErr0, 1'b1);
    checkOutput("misal_rdata_t2", rspRdata0, 32'd0);
    applyStimulus(0, 32'h0000_0100, 32'h3333_4444, 1'b1, 4'b0111, 1'b0);
    checkOutput("badtype_wren_t1", lsuWren, 1'b0);
    stepCycle();
    checkOutput("badtype_rsp0_t2", rspValid0, 1'b1);
    checkOutput("badtype_err_t2", rspErr0, 1'b1);

    // Reset during ST_ACC. The write strobe drops in that same cycle.
    applyStimulus(0, 32'h0000_0030, 32'h1234_5678, 1'b1, 4'b1111, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_stacc_wren", lsuWren, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reqAddr[0] = 32'h0000_0020;
    reqWdata[0] = 32'hCAFE_F00D;
    reqWren[0] = 1'b1;
    reqType[0] = 4'b1111;
    reqSigned[0] = 1'b0;
    reqAddr[1] = 32'h0000_0040;
    reqWdata[1] = 32'd0;
    reqWren[1] = 1'b0;
    reqType[1] = 4'b1111;
    reqSigned[1] = 1'b0;
    reqValid = 2'b11;
    #1;
    checkOutput("rst_no_rsp0", rspValid0, 1'b0);
    checkOutput("rst_conflict_rdy0", rdy0, 1'b1);
    checkOutput("rst_conflict_rdy1", rdy1, 1'b0);

    // Back-to-back: requester 1 is accepted in the same cycle as rsp0.
    @(posedge clk);
    #1;
    checkOutput("b2b_acc0", accFlag[0], 1'b1);
    reqValid[0] = 1'b0;
    #1;
    checkOutput("b2b_rdy1_t1", rdy1, 1'b0);
    checkOutput("b2b_wren_t1", lsuWren, 1'b1);
    stepCycle();
    checkOutput("b2b_rdy1_t2", rdy1, 1'b1);
    checkOutput("b2b_rsp0_t2", rspValid0, 1'b1);
    baseCyc = cycNow;

    // Both requesters hold continuous loads. Round-robin must alternate,
    // with accepts 3 cycles apart. The fixed-priority instance runs in the
    // same window and must only ever accept requester 0.
    nRec = 0;
    fpCount = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        reqAddr[0] = 32'h0000_0050;
        reqWdata[0] = 32'd0;
        reqWren[0] = 1'b0;
        reqType[0] = 4'b1111;
        reqSigned[0] = 1'b0;
        reqValid[0] = 1'b1;
      end
      if (accCyc == cycNow - 1 && accCyc > baseCyc && accFlag != 2'b00 && nRec < 4) begin
        recId[nRec] = accFlag[1] ? 1 : 0;
        recCyc[nRec] = accCyc;
        nRec++;
      end
      #1;
      if (k < 12) begin
        checkOutput("fixed_rdy1", fpRdy1, 1'b0);
        if (fpRdy0) fpCount++;
      end
    end
    reqValid = 2'b00;
    checkOutput("rr_count", nRec, 4);
    checkOutput("rr_first_cycle", recCyc[0] - baseCyc, 3);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_order", recId[i], i % 2);
      if (i > 0) checkOutput("rr_spacing", recCyc[i] - recCyc[i-1], 3);
    end
    checkOutput("fixed_rdy0_count", fpCount, 4);

    // Randomized traffic on the round-robin instance, with occasional resets.
    for (int n = 0; n < 800; n++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 99) == 0);
      ldData = $urandom;
      for (int id = 0; id < 2; id++) begin
        if (!reqValid[id] || (accFlag[id] && accCyc == cycNow - 1)) begin
          if ($urandom_range(0, 9) < 6) begin
            reqAddr[id] = {$urandom_range(0, 255), 2'b00} + $urandom_range(0, 3);
            reqWdata[id] = $urandom;
            reqWren[id] = $urandom_range(0, 1);
            reqSigned[id] = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
              0, 1, 2: reqType[id] = 4'b1111;
              3, 4:    reqType[id] = 4'b0011;
              5, 6:    reqType[id] = 4'b0001;
              default: reqType[id] = 4'($urandom_range(0, 15));
            endcase
            reqValid[id] = 1'b1;
          end else begin
            reqValid[id] = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    reqValid = 2'b00;
    repeat (6) @(posedge clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Shares the single LSU port between two requesters: requester 0 is the CPU memory stage and requester 1 is the debug/DMA port. Each accepted request is sequenced through a fixed multi-cycle access: address and control are held stable while the LSU is driven, and load data is captured and returned with a one-cycle response pulse. Misaligned or malformed requests are rejected without touching the LSU, so neither memory nor I/O registers are disturbed.

## Interface
- FIXED_PRIO, 0, 0: round-robin between requesters; 1: requester 0 always wins a conflict.
- i_clk  in  1  clock, all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_reqN_valid  in  1  request N pending (N = 0, 1); must be held with its fields stable until accepted.
- o_reqN_ready  out  1  request N accepted this cycle when valid & ready.
- i_reqN_addr  in  32  byte address.
- i_reqN_wdata  in  32  store data, right-aligned.
- i_reqN_wren  in  1  1 = store, 0 = load.
- i_reqN_load_type  in  4  0001 byte, 0011 halfword, 1111 word.
- i_reqN_load_signed  in  1  1 = sign-extend loads.
- o_rspN_valid  out  1  one-cycle response pulse for requester N.
- o_rspN_rdata  out  32  load result; 0 for stores and errors.
- o_rspN_err  out  1  qualified by o_rspN_valid; 1 = request rejected.
- o_lsu_addr  out  32  to LSU address.
- o_lsu_st_data  out  32  to LSU store data.
- o_lsu_wren  out  1  to LSU write enable.
- o_lsu_load_type  out  4  to LSU size.
- o_lsu_load_signed  out  1  to LSU sign control.
- i_lsu_ld_data  in  32  from LSU load data.

## Operation
- FSM states: IDLE, ST_ACC, LD_ACC, LD_CAP, ERR.
- IDLE grant rules:
  - If exactly one request is valid, that requester is granted.
  - If both are valid and FIXED_PRIO=0, the requester not granted last is granted.
  - If both are valid and FIXED_PRIO=1, requester 0 is granted.
- o_reqN_ready = (state==IDLE) & grantN & ~i_reset. This is combinational, and at most one ready is high per cycle.
- On accept:
  - addr, wdata, wren, load_type, load_signed and the requester id are latched.
  - last_grant is updated.
  - Next state is chosen:
    - ERR if the access is malformed: load_type is not one of 0001/0011/1111, or a halfword has addr[0]=1, or a word has addr[1:0]≠00.
    - Otherwise ST_ACC if wren=1.
    - Otherwise LD_ACC.
- ST_ACC: o_lsu_wren=1 for exactly this one cycle, then IDLE.
- LD_ACC: the LSU is driven with o_lsu_wren=0, then LD_CAP.
- LD_CAP: the LSU is still driven, and i_lsu_ld_data is registered into the response data at the end of the cycle. Then IDLE.
- ERR: no LSU write, then IDLE.
- Responses:
  - The response is registered and pulses o_rspN_valid for one cycle, for the latched requester only, in the cycle after ST_ACC / LD_CAP / ERR.
  - err=1 only from ERR. rdata is 0 except after LD_CAP.
- The o_lsu_* fields always show the latched request. o_lsu_wren = (state==ST_ACC) & ~i_reset.
- The response cycle coincides with IDLE, so a new request may be accepted in the same cycle a response pulses.

## Timing
- Accept in cycle T gives these responses:
  - Store: write at T+1, response at T+2.
  - Load: LSU read during T+1..T+2, response at T+3.
  - Error: response at T+2.
- Maximum throughput: one store per 2 cycles, one load per 3 cycles.
- Reset values:
  - state IDLE, last_grant = 1 (so requester 0 wins the first conflict).
  - All latched fields 0.
  - o_rspN_valid/err/rdata 0, o_lsu_wren 0, o_reqN_ready 0.
- Reset mid-access: the FSM returns to IDLE, o_lsu_wren is forced low in the reset cycle itself, and no response is issued for the aborted request.
- A requester that drops valid before ready is a protocol violation; no behaviour is guaranteed.

## Test plan
- Single store: req0 store word 0x0000_0010, wdata 0xDEADBEEF, accepted cycle T → o_lsu_wren=1 only at T+1 with addr 0x10. o_rsp0_valid=1 at T+2 with err=0.
- Single load: req1 load signed byte at addr 0x13, LSU returning 0xFFFF_FF80 → o_rsp1_valid at T+3 with rdata 0xFFFF_FF80. o_rsp0_valid stays 0.
- Round-robin: both requesters hold valid continuous loads with FIXED_PRIO=0 → accept order 0,1,0,1, with accepts spaced 3 cycles apart. Repeating with FIXED_PRIO=1 → requester 0 is always accepted.
- Misaligned: req0 word store at addr 0x0000_0002 → no o_lsu_wren pulse. o_rsp0_valid with err=1 and rdata 0 at T+2. The same check applies to load_type 0111.
- Back-to-back: req0 store accepted at T, and req1 is already valid → req1 is accepted at T+2, the same cycle o_rsp0_valid pulses.
- Reset in ST_ACC: assert i_reset in the ST_ACC cycle → o_lsu_wren=0 in that cycle. After reset: state IDLE, no response, and the next conflict is granted to requester 0.
